alu_4bit: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_barrel_shift.sv | 39 +++
 rtl/alu_4bit.sv | 84 ++++++++
 tb/tb_alu_4bit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding for the registered ALU and its decoder.
// The typedef keeps sel values self-documenting at every use site.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_ADD = 3'b000;
  localparam alu_op_t OP_SUB = 3'b001;
  localparam alu_op_t OP_AND = 3'b010;
  localparam alu_op_t OP_OR  = 3'b011;
  localparam alu_op_t OP_XOR = 3'b100;
  localparam alu_op_t OP_NOT = 3'b101;
  localparam alu_op_t OP_SHL = 3'b110;
  localparam alu_op_t OP_SHR = 3'b111;

endpackage

// File: rtl/alu_barrel_shift.sv
// Logical left/right shifter with shift-out bit, saturating to zero
// once the amount reaches the operand width.
module alu_barrel_shift #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amount,
  input  logic             left,
  output logic [WIDTH-1:0] shifted,
  output logic             shift_out
);

  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  logic [WIDTH:0] left_ext;
  logic [WIDTH:0] right_ext;
  logic           amount_over;
  logic           amount_full;

  // One guard bit beyond the operand catches the last bit shifted out.
  assign left_ext    = {1'b0, a} << amount;
  assign right_ext   = {a, 1'b0} >> amount;
  assign amount_over = (amount > SHIFT_LIMIT);
  assign amount_full = (amount >= SHIFT_LIMIT);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    shifted   = '0;
    shift_out = 1'b0;
    if (left) begin
      shifted   = amount_full ? '0 : left_ext[WIDTH-1:0];
      shift_out = amount_over ? 1'b0 : left_ext[WIDTH];
    end else begin
      shifted   = amount_full ? '0 : right_ext[WIDTH:1];
      shift_out = amount_over ? 1'b0 : right_ext[0];
    end
  end

endmodule

// File: rtl/alu_4bit.sv
// Registered ALU: a combinational next-value selection on sel feeding a
// single output register stage, one result per cycle, no stall.
module alu_4bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  alu_op_t          sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             c_out,
  output logic             zero
);

  logic             is_sub;
  logic [WIDTH-1:0] b_operand;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] shifted;
  logic             shift_out;
  logic [WIDTH-1:0] y_next;
  logic             c_next;

  // Add and subtract share one adder: SUB is A + ~B + 1, borrow = ~carry.
  assign is_sub    = (sel == OP_SUB);
  assign b_operand = is_sub ? ~B : B;
  assign sum       = {1'b0, A} + {1'b0, b_operand} + {{WIDTH{1'b0}}, is_sub};

  alu_barrel_shift #(
    .WIDTH(WIDTH)
  ) u_shift (
    .a        (A),
    .amount   (B),
    .left     (sel == OP_SHL),
    .shifted  (shifted),
    .shift_out(shift_out)
  );

  always_comb begin
    y_next = '0;
    c_next = 1'b0;
    unique case (sel)
      OP_ADD: begin
        y_next = sum[WIDTH-1:0];
        c_next = sum[WIDTH];
      end
      OP_SUB: begin
        y_next = sum[WIDTH-1:0];
        c_next = ~sum[WIDTH];
      end
      OP_AND: y_next = A & B;
      OP_OR:  y_next = A | B;
      OP_XOR: y_next = A ^ B;
      OP_NOT: y_next = ~A;
      OP_SHL, OP_SHR: begin
        y_next = shifted;
        c_next = shift_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      c_out     <= 1'b0;
      zero      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_valid <= in_valid;
      if (in_valid) begin
        y     <= y_next;
        c_out <= c_next;
        zero  <= (y_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
// Directed self-checking bench for alu_4bit with hand-computed vectors.
// Inputs change on the falling edge; outputs are sampled 1 ns after rising.
module tb_alu_4bit;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  alu_op_t    sel;
  logic       out_valid;
  logic [3:0] y;
  logic       c_out;
  logic       zero;

  int total = 0;
  int bad   = 0;

  alu_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .out_valid(out_valid),
    .y        (y),
    .c_out    (c_out),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One valid operation: present at negedge, registered at the next posedge.
  task automatic run_op(input alu_op_t op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    sel      = op;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ey, input logic ec,
                            input logic ez);
    check({tag, ".y"}, {4'b0, y}, {4'b0, ey});
    check({tag, ".c"}, {7'b0, c_out}, {7'b0, ec});
    check({tag, ".z"}, {7'b0, zero}, {7'b0, ez});
    check({tag, ".v"}, {7'b0, out_valid}, 8'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    sel      = OP_ADD;
    #12;
    check("rst.y", {4'b0, y}, 8'h00);
    check("rst.c", {7'b0, c_out}, 8'h00);
    check("rst.z", {7'b0, zero}, 8'h01);
    check("rst.v", {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_ADD, 4'b0011, 4'b0101); expect_out("add1", 4'b1000, 1'b0, 1'b0);
    run_op(OP_ADD, 4'b1111, 4'b0001); expect_out("add2", 4'b0000, 1'b1, 1'b1);
    run_op(OP_SUB, 4'b0110, 4'b0011); expect_out("sub1", 4'b0011, 1'b0, 1'b0);
    run_op(OP_SUB, 4'b0011, 4'b0110); expect_out("sub2", 4'b1101, 1'b1, 1'b0);
    run_op(OP_SUB, 4'b0101, 4'b0101); expect_out("sub3", 4'b0000, 1'b0, 1'b1);

    run_op(OP_AND, 4'b1100, 4'b1010); expect_out("and", 4'b1000, 1'b0, 1'b0);
    run_op(OP_OR,  4'b1100, 4'b1010); expect_out("or",  4'b1110, 1'b0, 1'b0);
    run_op(OP_XOR, 4'b1100, 4'b1010); expect_out("xor", 4'b0110, 1'b0, 1'b0);
    run_op(OP_NOT, 4'b1100, 4'b0000); expect_out("not", 4'b0011, 1'b0, 1'b0);

    run_op(OP_SHL, 4'b0001, 4'b0010); expect_out("shl1", 4'b0100, 1'b0, 1'b0);
    run_op(OP_SHL, 4'b1001, 4'b0001); expect_out("shl2", 4'b0010, 1'b1, 1'b0);
    run_op(OP_SHR, 4'b1000, 4'b0001); expect_out("shr1", 4'b0100, 1'b0, 1'b0);
    run_op(OP_SHR, 4'b0011, 4'b0001); expect_out("shr2", 4'b0001, 1'b1, 1'b0);
    run_op(OP_SHL, 4'b1111, 4'b0101); expect_out("shl5", 4'b0000, 1'b0, 1'b1);
    run_op(OP_SHR, 4'b1111, 4'b0101); expect_out("shr5", 4'b0000, 1'b0, 1'b1);
    run_op(OP_SHL, 4'b1001, 4'b0100); expect_out("shl4", 4'b0000, 1'b1, 1'b1);
    run_op(OP_SHR, 4'b1001, 4'b0100); expect_out("shr4", 4'b0000, 1'b1, 1'b1);
    run_op(OP_SHL, 4'b1011, 4'b0000); expect_out("shl0", 4'b1011, 1'b0, 1'b0);
    run_op(OP_SHR, 4'b0110, 4'b0011); expect_out("shr3", 4'b0000, 1'b1, 1'b1);

    // Back-to-back valid operations, then an idle cycle.
    run_op(OP_ADD, 4'b0001, 4'b0010); expect_out("b2b1", 4'b0011, 1'b0, 1'b0);
    run_op(OP_SUB, 4'b0101, 4'b0001); expect_out("b2b2", 4'b0100, 1'b0, 1'b0);
    run_op(OP_XOR, 4'b1111, 4'b1010); expect_out("b2b3", 4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    sel      = OP_ADD;
    A        = 4'b0000;
    B        = 4'b0000;
    @(posedge clk);
    #1;
    check("idle.v", {7'b0, out_valid}, 8'h00);
    check("idle.y", {4'b0, y}, 8'h05);
    check("idle.z", {7'b0, zero}, 8'h00);
    @(posedge clk);
    #1;
    check("idle2.y", {4'b0, y}, 8'h05);

    // Produce a nonzero result with carry, then reset asynchronously mid-cycle.
    run_op(OP_ADD, 4'b1111, 4'b0011); expect_out("pre", 4'b0010, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.y", {4'b0, y}, 8'h00);
    check("arst.c", {7'b0, c_out}, 8'h00);
    check("arst.z", {7'b0, zero}, 8'h01);
    check("arst.v", {7'b0, out_valid}, 8'h00);
    @(posedge clk);
    #1;
    check("hold.v", {7'b0, out_valid}, 8'h00);
    check("hold.y", {4'b0, y}, 8'h00);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    run_op(OP_ADD, 4'b0010, 4'b0010); expect_out("post", 4'b0100, 1'b0, 1'b0);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("end.v", {7'b0, out_valid}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
